// File: rtl/col_ram_scanner.sv
// Column-RAM scanner: snapshots the packed column words at frame start and streams every
// cell colour in index order (row*NUM_COLS + col) over valid/ready, plus a registered random read.
module col_ram_scanner #(
    parameter int                 NUM_COLS    = 13,
    parameter int                 ROWS        = 4,
    parameter int                 COLOR_W     = 3,
    parameter int                 SEL_W       = 6,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = '1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_COLS*ROWS*COLOR_W-1:0]  col_words,
    input  logic                              start,
    output logic                              busy,
    output logic                              pix_valid,
    input  logic                              pix_ready,
    output logic [SEL_W-1:0]                  pix_idx,
    output logic [COLOR_W-1:0]                pix_color,
    output logic                              pix_last,
    output logic                              frame_done,
    input  logic                              rd_en,
    input  logic [SEL_W-1:0]                  rd_sel,
    output logic                              rd_valid,
    output logic [COLOR_W-1:0]                rd_color,
    output logic                              rd_oob
);
    localparam int NUM_CELLS = NUM_COLS * ROWS;
    localparam int WORD_W    = ROWS * COLOR_W;
    localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [NUM_COLS*WORD_W-1:0] r_snap;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic [SEL_W-1:0]           r_idx;
    logic                       r_frame_done;
    logic                       r_rd_valid;
    logic                       r_rd_oob;
    logic [COLOR_W-1:0]         r_rd_color;
    logic                       w_load;
    logic                       w_xfer;
    logic                       w_last;
    logic                       w_oob;
    logic [COLOR_W-1:0]         w_snap_cell [NUM_COLS][ROWS];
    logic [COLOR_W-1:0]         w_live_cell [2**SEL_W];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign w_snap_cell[c][r] = r_snap[c*WORD_W + r*COLOR_W +: COLOR_W];
        end
    end

    // Live cells laid out by cell index over the whole select range; unused indices read blank.
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_live
        if (i < NUM_CELLS) begin : g_in
            assign w_live_cell[i] = col_words[(i % NUM_COLS)*WORD_W + (i / NUM_COLS)*COLOR_W +: COLOR_W];
        end else begin : g_out
            assign w_live_cell[i] = BLANK_COLOR;
        end
    end

    assign w_last = (r_idx == LAST_IDX);
    assign w_oob  = ({1'b0, rd_sel} >= (SEL_W+1)'(NUM_CELLS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        w_next_state = r_state;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: if (start) w_next_state = LOAD;
            LOAD: begin
                w_load       = 1'b1;
                w_next_state = SCAN;
            end
            SCAN: if (pix_ready) begin
                w_xfer = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Row/column counter pair tracks the index so no divider is needed on the scan path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == DONE);
            if (w_load) begin
                r_snap <= col_words;
                r_col  <= '0;
                r_row  <= '0;
                r_idx  <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_col <= '0;
                    r_row <= '0;
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + SEL_W'(1);
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
            r_rd_color <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_oob   <= w_oob;
                r_rd_color <= w_live_cell[rd_sel];
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign pix_valid  = (r_state == SCAN);
    assign pix_idx    = r_idx;
    assign pix_color  = w_snap_cell[r_col][r_row];
    assign pix_last   = w_last;
    assign frame_done = r_frame_done;
    assign rd_valid   = r_rd_valid;
    assign rd_color   = r_rd_color;
    assign rd_oob     = r_rd_oob;

endmodule
